mem_port_arbiter: RTL and testbench

- Shares the single LC-3 memory port (MAR/MDR side, ready-handshaked memory) between NREQ requesters, e.g. fetch, load/store and I/O.
- Serialises accesses with a round-robin grant pointer and holds the memory request stable until the memory asserts ready.
- Drives the select that routes read data back to the granted requester through the existing data demux.

---
 rtl/lc3_mem_pkg.sv | 13 +
 rtl/mem_port_arbiter_rr_pick.sv | 27 ++
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/lc3_mem_pkg.sv
// Shared constants for the LC-3 memory port arbiter: FSM state encoding and default widths.
package lc3_mem_pkg;

  localparam int unsigned DATASIZE_W = 16;
  localparam int unsigned ADDRSIZE_W = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Round-robin picker: first set request bit scanning upward from ptr_i, wrapping modulo NREQ.
module rr_pick #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned SELSIZE = 1
) (
  input  logic [NREQ-1:0]    req_i,
  input  logic [SELSIZE-1:0] ptr_i,
  output logic [SELSIZE-1:0] idx_o,
  output logic               valid_o
);

  logic [SELSIZE-1:0] cand;

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = SELSIZE'((32'(ptr_i) + k) % NREQ);
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises NREQ requesters onto the single ready-handshaked LC-3 memory port with a
// round-robin grant; rsel steers read data back through the existing demux.
module mem_port_arbiter
  import lc3_mem_pkg::*;
#(
  parameter int unsigned NREQ     = 2,
  parameter int unsigned SELSIZE  = 1,
  parameter int unsigned DATASIZE = DATASIZE_W,
  parameter int unsigned ADDRSIZE = ADDRSIZE_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          we,
  input  logic [NREQ*ADDRSIZE-1:0] addr,
  input  logic [NREQ*DATASIZE-1:0] wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic [DATASIZE-1:0]      rdata,
  output logic [SELSIZE-1:0]       rsel,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDRSIZE-1:0]      mem_addr,
  output logic [DATASIZE-1:0]      mem_wdata,
  input  logic [DATASIZE-1:0]      mem_rdata,
  input  logic                     mem_r
);

  state_t                state_q, state_d;
  logic [SELSIZE-1:0]    ptr_q, ptr_d;
  logic [NREQ-1:0]       gnt_q, gnt_d;
  logic [NREQ-1:0]       done_q, done_d;
  logic [DATASIZE-1:0]   rdata_q, rdata_d;
  logic [SELSIZE-1:0]    rsel_q, rsel_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDRSIZE-1:0]   mem_addr_q, mem_addr_d;
  logic [DATASIZE-1:0]   mem_wdata_q, mem_wdata_d;

  logic [SELSIZE-1:0]    pick_idx;
  logic                  pick_valid;

  rr_pick #(
    .NREQ    (NREQ),
    .SELSIZE (SELSIZE)
  ) u_rr_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // State and registered outputs; reset abandons any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      rsel_q      <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      rsel_q      <= rsel_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pick_valid) state_d = ST_BUSY;
      ST_BUSY: if (mem_r)      state_d = ST_DONE;
      ST_DONE:                 state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // Request fields are captured only on the IDLE grant, so BUSY ignores input changes.
  always_comb begin
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    done_d      = done_q;
    rdata_d     = rdata_q;
    rsel_d      = rsel_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          rsel_d      = pick_idx;
          mem_addr_d  = addr[32'(pick_idx) * ADDRSIZE +: ADDRSIZE];
          mem_wdata_d = wdata[32'(pick_idx) * DATASIZE +: DATASIZE];
          mem_we_d    = we[pick_idx];
          mem_en_d    = 1'b1;
          gnt_d       = NREQ'(1) << pick_idx;
        end
      end
      ST_BUSY: begin
        if (mem_r) begin
          if (!mem_we_q) rdata_d = mem_rdata;
          mem_en_d = 1'b0;
          done_d   = gnt_q;
          ptr_d    = (rsel_q == SELSIZE'(NREQ - 1)) ? '0 : rsel_q + SELSIZE'(1);
        end
      end
      ST_DONE: begin
        done_d = '0;
        gnt_d  = '0;
      end
      default: begin
        done_d   = '0;
        gnt_d    = '0;
        mem_en_d = 1'b0;
      end
    endcase
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign rsel      = rsel_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus reset and contention sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req = '0;
  logic [1:0]  we = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [1:0]  gnt, done;
  logic [15:0] rdata;
  logic        rsel;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_r = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NREQ(2), .SELSIZE(1), .DATASIZE(16), .ADDRSIZE(16)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .rdata(rdata), .rsel(rsel),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_r(mem_r)
  );

  typedef struct packed {
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [15:0] rdata;
    logic        rsel;
    logic        en;
    logic        mwe;
    logic [15:0] maddr;
    logic [15:0] mwd;
  } out_t;

  typedef struct packed {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [15:0] a0, a1, d0, d1;
    logic        mr;
    logic [15:0] mrd;
    out_t        exp;
  } vec_t;

  vec_t tbl[$];

  function automatic out_t cur_out();
    return '{gnt: gnt, done: done, rdata: rdata, rsel: rsel, en: mem_en,
             mwe: mem_we, maddr: mem_addr, mwd: mem_wdata};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic add(input logic [1:0] rq, input logic [1:0] w, input logic [15:0] a0,
                     input logic [15:0] a1, input logic [15:0] d0, input logic [15:0] d1,
                     input logic mr, input logic [15:0] mrd,
                     input logic [1:0] eg, input logic [1:0] ed, input logic [15:0] erd,
                     input logic es, input logic een, input logic ewe,
                     input logic [15:0] ea, input logic [15:0] ewd);
    vec_t v;
    v.req = rq; v.we = w; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.mr = mr; v.mrd = mrd;
    v.exp = '{gnt: eg, done: ed, rdata: erd, rsel: es, en: een, mwe: ewe, maddr: ea, mwd: ewd};
    tbl.push_back(v);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] prev_gnt;
  logic [1:0] exp_gnt;
  bit         seen;

  initial begin
    // req   we     a0       a1       d0       d1      mr  mrd      | gnt   done  rdata    rsel en  mwe addr     wdata
    // single read by requester 0, ready two cycles after mem_en
    add(2'b01,2'b00,16'h3000,16'h0000,16'h0000,16'h0000,1'b0,16'h0000, 2'b01,2'b00,16'h0000,1'b0,1'b1,1'b0,16'h3000,16'h0000);
    add(2'b01,2'b00,16'h3000,16'h0000,16'h0000,16'h0000,1'b0,16'h0000, 2'b01,2'b00,16'h0000,1'b0,1'b1,1'b0,16'h3000,16'h0000);
    add(2'b01,2'b00,16'h3000,16'h0000,16'h0000,16'h0000,1'b1,16'hABCD, 2'b01,2'b01,16'hABCD,1'b0,1'b0,1'b0,16'h3000,16'h0000);
    add(2'b00,2'b00,16'h3000,16'h0000,16'h0000,16'h0000,1'b0,16'h0000, 2'b00,2'b00,16'hABCD,1'b0,1'b0,1'b0,16'h3000,16'h0000);
    // single write by requester 1; rdata must not change
    add(2'b10,2'b10,16'h3000,16'hFE00,16'h0000,16'h0041,1'b0,16'h0000, 2'b10,2'b00,16'hABCD,1'b1,1'b1,1'b1,16'hFE00,16'h0041);
    add(2'b10,2'b10,16'h3000,16'hFE00,16'h0000,16'h0041,1'b1,16'h1234, 2'b10,2'b10,16'hABCD,1'b1,1'b0,1'b1,16'hFE00,16'h0041);
    add(2'b00,2'b00,16'h3000,16'hFE00,16'h0000,16'h0041,1'b0,16'h0000, 2'b00,2'b00,16'hABCD,1'b1,1'b0,1'b1,16'hFE00,16'h0041);
    // spurious ready while idle
    add(2'b00,2'b00,16'h3000,16'hFE00,16'h0000,16'h0041,1'b1,16'h5555, 2'b00,2'b00,16'hABCD,1'b1,1'b0,1'b1,16'hFE00,16'h0041);
    // stability: inputs toggle during a 5-cycle wait, req0 dropped before ready
    add(2'b01,2'b00,16'h1111,16'hFE00,16'h2222,16'h0041,1'b0,16'h0000, 2'b01,2'b00,16'hABCD,1'b0,1'b1,1'b0,16'h1111,16'h2222);
    add(2'b00,2'b01,16'hAAAA,16'hFE00,16'hBBBB,16'h0041,1'b0,16'h0000, 2'b01,2'b00,16'hABCD,1'b0,1'b1,1'b0,16'h1111,16'h2222);
    add(2'b01,2'b00,16'hCCCC,16'hFE00,16'hDDDD,16'h0041,1'b0,16'h0000, 2'b01,2'b00,16'hABCD,1'b0,1'b1,1'b0,16'h1111,16'h2222);
    add(2'b00,2'b01,16'h1234,16'hFE00,16'h5678,16'h0041,1'b0,16'h0000, 2'b01,2'b00,16'hABCD,1'b0,1'b1,1'b0,16'h1111,16'h2222);
    add(2'b11,2'b11,16'hEEEE,16'h0001,16'hFFFF,16'h0002,1'b0,16'h0000, 2'b01,2'b00,16'hABCD,1'b0,1'b1,1'b0,16'h1111,16'h2222);
    add(2'b01,2'b00,16'h1111,16'hFE00,16'h2222,16'h0041,1'b0,16'h0000, 2'b01,2'b00,16'hABCD,1'b0,1'b1,1'b0,16'h1111,16'h2222);
    add(2'b00,2'b00,16'h9999,16'hFE00,16'h8888,16'h0041,1'b1,16'h7777, 2'b01,2'b01,16'h7777,1'b0,1'b0,1'b0,16'h1111,16'h2222);
    add(2'b00,2'b00,16'h9999,16'hFE00,16'h8888,16'h0041,1'b0,16'h0000, 2'b00,2'b00,16'h7777,1'b0,1'b0,1'b0,16'h1111,16'h2222);

    #2 rst = 1'b1;
    #1;
    chk("reset_state", 64'(cur_out()), 64'(out_t'('0)));

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = 1'b0;
      req = tbl[i].req; we = tbl[i].we;
      addr = {tbl[i].a1, tbl[i].a0}; wdata = {tbl[i].d1, tbl[i].d0};
      mem_r = tbl[i].mr; mem_rdata = tbl[i].mrd;
      cyc();
      chk($sformatf("vec%0d", i), 64'(cur_out()), 64'(tbl[i].exp));
    end

    // reset during the second wait cycle of a read by requester 0 (ptr is 1 beforehand)
    @(negedge clk);
    req = 2'b01; we = 2'b00; addr = {16'h0000, 16'h4000}; wdata = '0; mem_r = 1'b0;
    cyc();
    chk("rst_seq_grant", 64'({gnt, mem_en, mem_addr}), 64'({2'b01, 1'b1, 16'h4000}));
    @(negedge clk);
    cyc();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_async", 64'(cur_out()), 64'(out_t'('0)));
    @(negedge clk);
    rst = 1'b0; req = 2'b11;
    cyc();
    chk("rst_ptr_cleared", 64'({gnt, done, mem_en}), 64'({2'b01, 2'b00, 1'b1}));
    @(negedge clk);
    mem_r = 1'b1; mem_rdata = 16'h0F0F;
    cyc();
    chk("post_rst_done", 64'({done, rdata}), 64'({2'b01, 16'h0F0F}));
    @(negedge clk);
    mem_r = 1'b0; req = 2'b10;
    cyc();
    chk("post_rst_idle", 64'({gnt, done}), 64'({2'b00, 2'b00}));
    @(negedge clk);
    cyc();
    chk("req1_alone_grant", 64'({gnt, rsel, mem_en}), 64'({2'b10, 1'b1, 1'b1}));
    @(negedge clk);
    mem_r = 1'b1; mem_rdata = 16'h3C3C;
    cyc();
    chk("req1_alone_done", 64'({done, gnt}), 64'({2'b10, 2'b10}));

    // contention: both held, grants must rotate 0,1,0,1 starting from ptr=0
    @(negedge clk);
    mem_r = 1'b0; req = 2'b11;
    prev_gnt = 2'b10;
    for (int n = 0; n < 4; n++) begin
      exp_gnt = (n % 2 == 0) ? 2'b01 : 2'b10;
      seen = 1'b0;
      for (int t = 0; t < 8 && !seen; t++) begin
        cyc();
        if (mem_en) seen = 1'b1;
        else @(negedge clk);
      end
      chk($sformatf("cont%0d_granted", n), 64'(seen), 64'(1'b1));
      chk($sformatf("cont%0d_gnt", n), 64'(gnt), 64'(exp_gnt));
      total++;
      if (gnt == prev_gnt) begin
        bad++;
        $display("FAIL cont%0d_repeat: got=%b previous=%b must differ", n, gnt, prev_gnt);
      end
      prev_gnt = gnt;
      @(negedge clk);
      mem_r = 1'b1; mem_rdata = 16'(n);
      cyc();
      chk($sformatf("cont%0d_done", n), 64'({done, rdata}), 64'({exp_gnt, 16'(n)}));
      @(negedge clk);
      mem_r = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
